// File: rtl/xillybus_mem_pkg.sv
// Shared constants and helpers for the seekable Xillybus memory endpoint.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package xillybus_mem_pkg;

  // Top-of-memory behaviour selector for the WRAP parameter.
  localparam bit WRAP_ROLL = 1'b1;  // pointer rolls over to 0
  localparam bit WRAP_EOF  = 1'b0;  // pointer rolls to 0 and raises end-of-file

  // Number of words addressed by an ADDR_W-bit pointer.
  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/xillybus_dpram.sv
// Read-first true dual-port RAM, DEPTH x DATA_W, with separate read/write enables per port.
// Latency: 1 cycle read on either port; written data is readable the following cycle.
// Backpressure: none; every enabled access completes in the cycle it is presented.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset (clears read registers,
//                       blocks writes; array contents are never reset)
//   a_re/a_we/a_addr  : port A read enable, write enable, address
//   a_din/a_dout      : port A write data / registered read data
//   b_re/b_we/b_addr  : port B read enable, write enable, address
//   b_din/b_dout      : port B write data / registered read data
// Port A wins when both ports write the same address in one cycle.
module xillybus_dpram
  import xillybus_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_re,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_re,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout
);

  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both writes live in one process so the collision rule is explicit:
  // the port A assignment comes last and therefore takes effect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (b_we) mem[b_addr] <= b_din;
      if (a_we) mem[a_addr] <= a_din;
    end
  end

  // Non-blocking reads sample the array before this edge's writes land,
  // giving read-first behaviour on both ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      if (a_re) a_dout <= mem[a_addr];
      if (b_re) b_dout <= mem[b_addr];
    end
  end

endmodule

// File: rtl/xillybus_mem_port.sv
// Seekable Xillybus memory endpoint with an application-side port onto the same RAM.
// Latency: 1 cycle for host and application reads; seeks affect the next access.
// Backpressure: with WRAP=0, empty/eof/full assert once the pointer runs off the top
//               and stay up until a seek or a file-open rising edge; with WRAP=1 never.
//
// Ports:
//   bus_clk, bus_rst                      : clock, synchronous active-high reset
//   user_w_wren/data/full/open            : host write stream
//   user_r_rden/data/empty/eof/open       : host read stream
//   user_addr, user_addr_update           : seek address and one-cycle seek strobe
//   app_en/we/addr/din/dout               : application RAM port
module xillybus_mem_port
  import xillybus_mem_pkg::*;
#(
  parameter int DATA_W = 8,         // 8, 16 or 32
  parameter int ADDR_W = 5,
  parameter bit WRAP   = WRAP_ROLL
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic              user_w_wren,
  input  logic [DATA_W-1:0] user_w_data,
  output logic              user_w_full,
  input  logic              user_w_open,
  input  logic              user_r_rden,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_empty,
  output logic              user_r_eof,
  input  logic              user_r_open,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic              user_addr_update,
  input  logic              app_en,
  input  logic              app_we,
  input  logic [ADDR_W-1:0] app_addr,
  input  logic [DATA_W-1:0] app_din,
  output logic [DATA_W-1:0] app_dout
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(depth(ADDR_W) - 1);

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              end_flag;
  logic              end_flag_nxt;
  logic              r_open_q;
  logic              w_open_q;

  logic host_rd;
  logic host_wr;
  logic advance;
  logic open_rise;

  always_comb begin
    host_rd      = user_r_rden && !end_flag;
    host_wr      = user_w_wren && !end_flag;
    advance      = host_rd || host_wr;
    open_rise    = (user_r_open && !r_open_q) || (user_w_open && !w_open_q);
    ptr_nxt      = ptr;
    end_flag_nxt = end_flag;

    if (user_addr_update) begin
      // Seek beats advance; any access this cycle already used the old ptr.
      ptr_nxt      = user_addr;
      end_flag_nxt = 1'b0;
    end else begin
      if (advance) begin
        // Natural ADDR_W-bit overflow takes DEPTH-1 back to 0 in both modes.
        ptr_nxt = ptr + ADDR_W'(1);
      end
      if (open_rise) begin
        end_flag_nxt = 1'b0;
      end else if (advance && (ptr == TOP_ADDR) && (WRAP == WRAP_EOF)) begin
        end_flag_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      ptr      <= '0;
      end_flag <= 1'b0;
      r_open_q <= 1'b0;
      w_open_q <= 1'b0;
    end else begin
      ptr      <= ptr_nxt;
      end_flag <= end_flag_nxt;
      r_open_q <= user_r_open;
      w_open_q <= user_w_open;
    end
  end

  // end_flag is itself a register and can never set in roll mode, so the
  // three hold-off flags are registered and constant 0 when WRAP=1.
  assign user_r_empty = end_flag;
  assign user_r_eof   = end_flag;
  assign user_w_full  = end_flag;

  // Host is port A so it wins a same-address write collision.
  xillybus_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (bus_clk),
    .rst    (bus_rst),
    .a_re   (host_rd),
    .a_we   (host_wr),
    .a_addr (ptr),
    .a_din  (user_w_data),
    .a_dout (user_r_data),
    .b_re   (app_en),
    .b_we   (app_en && app_we),
    .b_addr (app_addr),
    .b_din  (app_din),
    .b_dout (app_dout)
  );

endmodule

// File: tb/tb_xillybus_mem_port.sv
module tb_xillybus_mem_port;

  typedef struct {
    logic        rst;
    logic        wren;
    logic [31:0] wdata;
    logic        rden;
    logic        upd;
    logic [4:0]  addr;
    logic        app_en;
    logic        app_we;
    logic [4:0]  app_addr;
    logic [31:0] app_din;
    logic        r_open;
    logic        w_open;
    logic        chk_rd;
    logic [31:0] exp_rd_roll;
    logic [31:0] exp_rd_eof;
    logic        chk_fl;
    logic        exp_fl_eof;
    logic        chk_ad;
    logic [31:0] exp_ad;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, wren, rden, upd, app_en, app_we, r_open, w_open;
  logic [31:0] wdata, app_din;
  logic [4:0]  addr, app_addr;

  logic [31:0] rd_roll, ad_roll, rd_eof, ad_eof;
  logic        full_roll, empty_roll, eof_roll, full_eof, empty_eof, eof_eof;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: index 0 = roll-mode DUT, index 1 = end-of-file DUT.
  logic [31:0] m_mem [2][32];
  int          m_ptr [2];
  bit          m_end [2];
  logic [31:0] m_rd  [2];
  logic [31:0] m_ad  [2];
  bit          m_prev_r, m_prev_w;

  vec_t tbl[$];

  always #5 clk = ~clk;

  xillybus_mem_port #(.DATA_W(32), .ADDR_W(5), .WRAP(1'b1)) dut_roll (
    .bus_clk(clk), .bus_rst(rst),
    .user_w_wren(wren), .user_w_data(wdata), .user_w_full(full_roll), .user_w_open(w_open),
    .user_r_rden(rden), .user_r_data(rd_roll), .user_r_empty(empty_roll), .user_r_eof(eof_roll),
    .user_r_open(r_open), .user_addr(addr), .user_addr_update(upd),
    .app_en(app_en), .app_we(app_we), .app_addr(app_addr), .app_din(app_din), .app_dout(ad_roll)
  );

  xillybus_mem_port #(.DATA_W(32), .ADDR_W(5), .WRAP(1'b0)) dut_eof (
    .bus_clk(clk), .bus_rst(rst),
    .user_w_wren(wren), .user_w_data(wdata), .user_w_full(full_eof), .user_w_open(w_open),
    .user_r_rden(rden), .user_r_data(rd_eof), .user_r_empty(empty_eof), .user_r_eof(eof_eof),
    .user_r_open(r_open), .user_addr(addr), .user_addr_update(upd),
    .app_en(app_en), .app_we(app_we), .app_addr(app_addr), .app_din(app_din), .app_dout(ad_eof)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if ($isunknown(exp)) return;  // model does not yet know this RAM word
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one call per clock edge, straight from the endpoint rules.
  task automatic model_step(input vec_t v);
    bit rise, adv, wrapped;
    rise = (v.r_open && !m_prev_r) || (v.w_open && !m_prev_w);
    for (int d = 0; d < 2; d++) begin
      if (v.rst) begin
        m_ptr[d] = 0; m_end[d] = 0; m_rd[d] = '0; m_ad[d] = '0;
        continue;
      end
      if (v.app_en)              m_ad[d] = m_mem[d][v.app_addr];
      if (v.rden && !m_end[d])   m_rd[d] = m_mem[d][m_ptr[d]];
      if (v.app_en && v.app_we)  m_mem[d][v.app_addr] = v.app_din;
      if (v.wren && !m_end[d])   m_mem[d][m_ptr[d]] = v.wdata;
      adv = (v.rden || v.wren) && !m_end[d];
      wrapped = 0;
      if (v.upd) begin
        m_ptr[d] = int'(v.addr);
        m_end[d] = 0;
      end else begin
        if (adv) begin
          if (m_ptr[d] == 31) begin m_ptr[d] = 0; wrapped = 1; end
          else m_ptr[d] = m_ptr[d] + 1;
        end
        if (rise)                  m_end[d] = 0;
        else if (wrapped && d == 1) m_end[d] = 1;
      end
    end
    if (v.rst) begin m_prev_r = 0; m_prev_w = 0; end
    else       begin m_prev_r = v.r_open; m_prev_w = v.w_open; end
  endtask

  task automatic apply(input vec_t v, input string tag);
    rst = v.rst; wren = v.wren; wdata = v.wdata; rden = v.rden;
    upd = v.upd; addr = v.addr; app_en = v.app_en; app_we = v.app_we;
    app_addr = v.app_addr; app_din = v.app_din; r_open = v.r_open; w_open = v.w_open;
    @(posedge clk);
    model_step(v);
    @(negedge clk);
    check("roll_rdata", rd_roll, m_rd[0]);
    check("roll_adout", ad_roll, m_ad[0]);
    check("roll_flags", {29'd0, empty_roll, eof_roll, full_roll}, {29'd0, {3{m_end[0]}}});
    check("eof_rdata", rd_eof, m_rd[1]);
    check("eof_adout", ad_eof, m_ad[1]);
    check("eof_flags", {29'd0, empty_eof, eof_eof, full_eof}, {29'd0, {3{m_end[1]}}});
    if (v.chk_rd) begin
      check({tag, "_rd_roll"}, rd_roll, v.exp_rd_roll);
      check({tag, "_rd_eof"},  rd_eof,  v.exp_rd_eof);
    end
    if (v.chk_fl) begin
      check({tag, "_fl_roll"}, {29'd0, empty_roll, eof_roll, full_roll}, 32'd0);
      check({tag, "_fl_eof"},  {29'd0, empty_eof, eof_eof, full_eof}, {29'd0, {3{v.exp_fl_eof}}});
    end
    if (v.chk_ad) begin
      check({tag, "_ad_roll"}, ad_roll, v.exp_ad);
      check({tag, "_ad_eof"},  ad_eof,  v.exp_ad);
    end
  endtask

  function automatic vec_t nv();
    vec_t v;
    v = '{default: '0};
    v.r_open = 1'b1;
    v.w_open = 1'b1;
    return v;
  endfunction

  function automatic vec_t seek(input int a);
    vec_t v = nv(); v.upd = 1; v.addr = 5'(a); return v;
  endfunction
  function automatic vec_t wr(input logic [31:0] d);
    vec_t v = nv(); v.wren = 1; v.wdata = d; return v;
  endfunction
  function automatic vec_t rd();
    vec_t v = nv(); v.rden = 1; return v;
  endfunction
  function automatic vec_t appw(input int a, input logic [31:0] d);
    vec_t v = nv(); v.app_en = 1; v.app_we = 1; v.app_addr = 5'(a); v.app_din = d; return v;
  endfunction

  task automatic exp_rd(input logic [31:0] r, input logic [31:0] e);
    tbl[tbl.size()-1].chk_rd = 1; tbl[tbl.size()-1].exp_rd_roll = r; tbl[tbl.size()-1].exp_rd_eof = e;
  endtask
  task automatic exp_fl(input logic f);
    tbl[tbl.size()-1].chk_fl = 1; tbl[tbl.size()-1].exp_fl_eof = f;
  endtask
  task automatic exp_ad(input logic [31:0] a);
    tbl[tbl.size()-1].chk_ad = 1; tbl[tbl.size()-1].exp_ad = a;
  endtask

  localparam logic [31:0] PAT = 32'hC0DE_0000;

  initial begin
    vec_t v;
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_end[d] = 0; m_rd[d] = '0; m_ad[d] = '0;
      for (int i = 0; i < 32; i++) m_mem[d][i] = 'x;
    end
    m_prev_r = 0; m_prev_w = 0;

    // Reset, then preload every word through the application port.
    v = nv(); v.rst = 1;
    apply(v, "reset");
    apply(v, "reset");
    for (int i = 0; i < 32; i++) apply(appw(i, PAT | 32'(i)), "init");

    // Directed sequences with hand-derived expectations.
    tbl.push_back(seek(3));
    tbl.push_back(wr(32'hA1));
    tbl.push_back(wr(32'hB2));
    tbl.push_back(seek(3));
    tbl.push_back(rd());  exp_rd(32'hA1, 32'hA1);
    tbl.push_back(rd());  exp_rd(32'hB2, 32'hB2);
    tbl.push_back(rd());  exp_rd(PAT | 32'd5, PAT | 32'd5);        // ptr was 5
    tbl.push_back(seek(31));
    tbl.push_back(wr(32'h11)); exp_fl(1);                          // eof DUT hits top
    tbl.push_back(wr(32'h22)); exp_fl(1);                          // roll writes mem[0]
    tbl.push_back(seek(31));   exp_fl(0);
    tbl.push_back(rd());  exp_rd(32'h11, 32'h11); exp_fl(1);
    tbl.push_back(rd());  exp_rd(32'h22, 32'h11); exp_fl(1);       // eof DUT holds data
    tbl.push_back(seek(0));    exp_fl(0);
    tbl.push_back(rd());  exp_rd(32'h22, PAT);                     // ignored write left PAT
    tbl.push_back(seek(2));
    v = seek(7); v.rden = 1;
    tbl.push_back(v);     exp_rd(PAT | 32'd2, PAT | 32'd2);
    tbl.push_back(rd());  exp_rd(PAT | 32'd7, PAT | 32'd7);        // ptr 7, not 8
    tbl.push_back(appw(9, 32'hDEADBEEF)); exp_ad(PAT | 32'd9);     // read-first
    tbl.push_back(seek(9));
    tbl.push_back(rd());  exp_rd(32'hDEADBEEF, 32'hDEADBEEF);
    tbl.push_back(seek(4));
    v = appw(4, 32'hCAFEF00D); v.wren = 1; v.wdata = 32'h12345678;
    tbl.push_back(v);     exp_ad(32'hB2);                          // collision, old word
    v = nv(); v.app_en = 1; v.app_addr = 5'd4;
    tbl.push_back(v);     exp_ad(32'h12345678);                    // host write won
    tbl.push_back(seek(31));
    tbl.push_back(rd());  exp_rd(32'h11, 32'h11); exp_fl(1);
    v = nv(); v.r_open = 0;
    tbl.push_back(v);     exp_fl(1);
    tbl.push_back(nv());  exp_fl(0);                               // open rising edge
    tbl.push_back(rd());  exp_rd(32'h22, PAT); exp_fl(0);          // ptr stayed at 0
    v = wr(32'h55); v.rst = 1;
    tbl.push_back(v);     exp_rd(0, 0); exp_fl(0); exp_ad(0);
    tbl.push_back(seek(1));
    tbl.push_back(rd());  exp_rd(PAT | 32'd1, PAT | 32'd1);        // no write during reset

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      v = nv();
      v.rst      = ($urandom_range(0, 199) == 0);
      v.wren     = ($urandom_range(0, 9) < 4);
      v.wdata    = $urandom;
      v.rden     = ($urandom_range(0, 9) < 4);
      v.upd      = ($urandom_range(0, 9) == 0);
      v.addr     = ($urandom_range(0, 2) == 0) ? 5'(31 - $urandom_range(0, 2)) : 5'($urandom);
      v.app_en   = 1'($urandom_range(0, 1));
      v.app_we   = 1'($urandom_range(0, 1));
      v.app_addr = 5'($urandom);
      v.app_din  = $urandom;
      v.r_open   = ($urandom_range(0, 19) != 0);
      v.w_open   = ($urandom_range(0, 19) != 0);
      apply(v, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
